pq_shift_array: RTL and testbench
=================================

Name: pq_shift_array

Overview:
- Register-array hardware priority queue: the baseline HWPQ implementation built on the shared package types.
- Stores up to CAPACITY kv_t entries, sorted by ascending key; the smallest key is highest priority.
- Presents the standard HWPQ enq/deq interface that every queue implementation in the study shares. The comparison benches drive it directly.
- One-cycle enqueue, dequeue and replace (simultaneous enq+deq) through per-slot compare-and-shift logic.

Parameters:
- CAPACITY, default pq_pkg::PQ_CAPACITY (4): number of storage slots; must be >= 2.
- CNT_W, default $clog2(CAPACITY+1): width of the occupancy counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- enq  in  1  enqueue request; kvi is inserted this cycle if accepted.
- kvi  in  pq_pkg::kv_t (KEY_WIDTH+VAL_WIDTH)  entry to insert.
- deq  in  1  dequeue request; head (kvo) is removed this cycle if accepted.
- kvo  out  pq_pkg::kv_t  current head (minimum key); combinational from slot 0.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- count  out  CNT_W  number of valid entries.

Behaviour:
- Reset (rst=1 at an edge): all slots <- KV_EMPTY, count <- 0. Outputs: kvo=KV_EMPTY, empty=1, full=0, count=0. Reset overrides enq/deq in the same cycle. Mid-operation reset discards all contents.
- State: slot[0..CAPACITY-1] of kv_t plus a count register. Invariants:
  - slot[i].key <= slot[i+1].key for i < count-1.
  - Slots at index >= count hold KV_EMPTY.
- Validity is determined by count only. A user entry whose key is KEYINF is legal and is stored normally.
- Acceptance:
  - enq_ok = enq && (!full || deq_ok).
  - deq_ok = deq && !empty.
- Ignored requests:
  - deq when empty is ignored; no state change.
  - enq when full and not deq is ignored; entry dropped; no error flag.
- Dequeue only: slot[i] <- slot[i+1]; slot[CAPACITY-1] <- KV_EMPTY; count-1.
- Enqueue only: p = number of valid entries with key <= kvi.key. Then slot[i] <- slot[i-1] for i > p, slot[p] <- kvi, count+1.
- Replace (enq_ok && deq_ok):
  - Result equals a dequeue followed by an enqueue into the shifted array, in one cycle. Count unchanged.
  - Legal when full; after replace, full stays 1.
- enq and deq both asserted while empty: deq ignored, enq accepted, count 1.
- Ties: equal keys leave in FIFO order; a new entry is placed after all existing entries with the same key.
- Latency:
  - An entry accepted at edge N is visible on kvo after edge N if it is the new minimum.
  - kvo, full, empty and count are registered-state derived, with no combinational path from enq/deq/kvi.
- Key compare is unsigned on the KEY_WIDTH field only; value is payload and never compared.
- kvo = slot[0], which is KV_EMPTY whenever empty=1.

Test Plan (CAPACITY=4, kv written key:value):
- Reset, then idle -> kvo=KV_EMPTY ({32'hFFFFFFFF,0}), empty=1, full=0, count=0. deq while empty -> no change.
- Enqueue 30:A, 10:B, 20:C, 5:D on consecutive cycles -> kvo 30:A, 10:B, 10:B, 5:D after each edge. full=1, count=4. Four deqs return 5:D, 10:B, 20:C, 30:A, then empty=1.
- Full with {5,10,20,30}, enq 1:E without deq -> ignored, count=4, kvo=5:D. Same cycle enq 1:E + deq -> kvo=1:E, count=4, contents {1,10,20,30}.
- Tie ordering: enq 7:X, 7:Y, 7:Z -> deqs yield X, Y, Z in order. Replace with enq 7:W while head 7:X -> next heads Y, Z, W.
- Empty queue, enq 9:F and deq same cycle -> count=1, kvo=9:F, empty=0.
- Reset asserted with count=3 and enq=1 in the same cycle -> after edge count=0, kvo=KV_EMPTY, and kvi is not stored.

Source files
------------

// File: rtl/pq_shift_array.sv
// Register-array priority queue: slots kept sorted by ascending key,
// with one-cycle enqueue, dequeue and replace via compare-and-shift.
package pq_pkg;
    localparam int KEY_WIDTH   = 32;
    localparam int VAL_WIDTH   = 32;
    localparam int PQ_CAPACITY = 4;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    localparam logic [KEY_WIDTH-1:0] KEYINF   = '1;
    localparam kv_t                  KV_EMPTY = '{key: KEYINF, val: '0};
endpackage

module pq_shift_array
    import pq_pkg::*;
#(
    parameter int CAPACITY = pq_pkg::PQ_CAPACITY,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  kv_t              kvi,
    input  logic             deq,
    output kv_t              kvo,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    kv_t              slot_q [CAPACITY];
    kv_t              slot_d [CAPACITY];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    kv_t              shf    [CAPACITY];
    logic [CNT_W-1:0] cnt_s;
    logic [CAPACITY-1:0] le;
    logic             enq_ok;
    logic             deq_ok;

    assign full  = (count_q == CNT_W'(CAPACITY));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign kvo   = slot_q[0];

    assign deq_ok = deq && !empty;
    assign enq_ok = enq && (!full || deq_ok);

    // Dequeue is applied first; the enqueue then inserts into the shifted array.
    always_comb begin
        for (int i = 0; i < CAPACITY; i++) begin
            shf[i] = slot_q[i];
        end
        cnt_s = count_q;
        if (deq_ok) begin
            for (int i = 0; i < CAPACITY - 1; i++) begin
                shf[i] = slot_q[i+1];
            end
            shf[CAPACITY-1] = KV_EMPTY;
            cnt_s = count_q - 1'b1;
        end
    end

    // le[i]: valid entry that stays ahead of kvi (ties keep FIFO order).
    always_comb begin
        le = '0;
        for (int i = 0; i < CAPACITY; i++) begin
            le[i] = (CNT_W'(i) < cnt_s) && (shf[i].key <= kvi.key);
        end
    end

    always_comb begin
        for (int i = 0; i < CAPACITY; i++) begin
            slot_d[i] = shf[i];
        end
        count_d = cnt_s;
        if (enq_ok) begin
            count_d = cnt_s + 1'b1;
            for (int i = 0; i < CAPACITY; i++) begin
                if (le[i]) begin
                    slot_d[i] = shf[i];
                end else if (i == 0) begin
                    slot_d[i] = kvi;
                end else if (le[i-1]) begin
                    slot_d[i] = kvi;
                end else begin
                    slot_d[i] = shf[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CAPACITY; i++) begin
                slot_q[i] <= KV_EMPTY;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < CAPACITY; i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_pq_shift_array.sv
// Directed bench for pq_shift_array at CAPACITY=4.
module tb_pq_shift_array;
    import pq_pkg::*;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          enq;
    logic          deq;
    kv_t           kvi;
    kv_t           kvo;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    pq_shift_array #(.CAPACITY(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .enq  (enq),
        .kvi  (kvi),
        .deq  (deq),
        .kvo  (kvo),
        .full (full),
        .empty(empty),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic kv_t kv(input logic [31:0] k, input logic [31:0] v);
        kv_t r;
        r.key = k;
        r.val = v;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic d,
                        input kv_t k);
        rst = r;
        enq = e;
        deq = d;
        kvi = k;
        @(posedge clk);
        #1;
        rst = 1'b0;
        enq = 1'b0;
        deq = 1'b0;
        kvi = KV_EMPTY;
    endtask

    task automatic status(input string tag, input logic [2:0] c,
                          input logic f, input logic e);
        chk({tag, "_count"}, 64'(count), 64'(c));
        chk({tag, "_full"}, 64'(full), 64'(f));
        chk({tag, "_empty"}, 64'(empty), 64'(e));
    endtask

    initial begin
        rst = 1'b1;
        enq = 1'b0;
        deq = 1'b0;
        kvi = KV_EMPTY;

        // reset and idle
        step(1, 0, 0, KV_EMPTY);
        step(0, 0, 0, KV_EMPTY);
        chk("rst_kvo", kvo, 64'hFFFFFFFF_00000000);
        status("rst", 0, 0, 1);
        step(0, 0, 1, KV_EMPTY);
        chk("deq_empty_kvo", kvo, 64'hFFFFFFFF_00000000);
        status("deq_empty", 0, 0, 1);

        // fill and drain
        step(0, 1, 0, kv(30, 'hA));
        chk("enq30", kvo, kv(30, 'hA));
        step(0, 1, 0, kv(10, 'hB));
        chk("enq10", kvo, kv(10, 'hB));
        step(0, 1, 0, kv(20, 'hC));
        chk("enq20", kvo, kv(10, 'hB));
        step(0, 1, 0, kv(5, 'hD));
        chk("enq5", kvo, kv(5, 'hD));
        status("fill", 4, 1, 0);
        chk("drain0", kvo, kv(5, 'hD));
        step(0, 0, 1, KV_EMPTY);
        chk("drain1", kvo, kv(10, 'hB));
        step(0, 0, 1, KV_EMPTY);
        chk("drain2", kvo, kv(20, 'hC));
        step(0, 0, 1, KV_EMPTY);
        chk("drain3", kvo, kv(30, 'hA));
        step(0, 0, 1, KV_EMPTY);
        chk("drained_kvo", kvo, KV_EMPTY);
        status("drained", 0, 0, 1);

        // full: enq dropped, then replace
        step(0, 1, 0, kv(30, 'hA));
        step(0, 1, 0, kv(10, 'hB));
        step(0, 1, 0, kv(20, 'hC));
        step(0, 1, 0, kv(5, 'hD));
        step(0, 1, 0, kv(1, 'hE));
        chk("full_drop_kvo", kvo, kv(5, 'hD));
        status("full_drop", 4, 1, 0);
        step(0, 1, 1, kv(1, 'hE));
        chk("repl_kvo", kvo, kv(1, 'hE));
        status("repl", 4, 1, 0);
        step(0, 0, 1, KV_EMPTY);
        chk("repl_c1", kvo, kv(10, 'hB));
        step(0, 0, 1, KV_EMPTY);
        chk("repl_c2", kvo, kv(20, 'hC));
        step(0, 0, 1, KV_EMPTY);
        chk("repl_c3", kvo, kv(30, 'hA));
        step(0, 0, 1, KV_EMPTY);
        status("repl_drained", 0, 0, 1);

        // ties leave in FIFO order
        step(0, 1, 0, kv(7, 'h58));
        step(0, 1, 0, kv(7, 'h59));
        step(0, 1, 0, kv(7, 'h5A));
        chk("tie0", kvo, kv(7, 'h58));
        step(0, 0, 1, KV_EMPTY);
        chk("tie1", kvo, kv(7, 'h59));
        step(0, 0, 1, KV_EMPTY);
        chk("tie2", kvo, kv(7, 'h5A));
        step(0, 0, 1, KV_EMPTY);
        status("tie_drained", 0, 0, 1);

        // tie replace: W goes behind Y and Z
        step(0, 1, 0, kv(7, 'h58));
        step(0, 1, 0, kv(7, 'h59));
        step(0, 1, 0, kv(7, 'h5A));
        step(0, 1, 1, kv(7, 'h57));
        chk("trep0", kvo, kv(7, 'h59));
        chk("trep_count", 64'(count), 64'(3));
        step(0, 0, 1, KV_EMPTY);
        chk("trep1", kvo, kv(7, 'h5A));
        step(0, 0, 1, KV_EMPTY);
        chk("trep2", kvo, kv(7, 'h57));
        step(0, 0, 1, KV_EMPTY);
        status("trep_drained", 0, 0, 1);

        // enq+deq on empty queue
        step(0, 1, 1, kv(9, 'hF));
        chk("ed_empty_kvo", kvo, kv(9, 'hF));
        status("ed_empty", 1, 0, 0);

        // reset overrides enq mid-operation
        step(0, 1, 0, kv(2, 'h6));
        step(0, 1, 0, kv(4, 'h7));
        chk("pre_rst_count", 64'(count), 64'(3));
        chk("pre_rst_kvo", kvo, kv(2, 'h6));
        step(1, 1, 0, kv(1, 'h8));
        chk("mid_rst_kvo", kvo, KV_EMPTY);
        status("mid_rst", 0, 0, 1);
        step(0, 0, 0, KV_EMPTY);
        status("post_rst", 0, 0, 1);

        // KEYINF key is a legal entry
        step(0, 1, 0, kv(32'hFFFFFFFF, 'h7));
        chk("keyinf_kvo", kvo, kv(32'hFFFFFFFF, 'h7));
        status("keyinf", 1, 0, 0);
        step(0, 1, 0, kv(3, 'h1));
        chk("keyinf_after", kvo, kv(3, 'h1));
        step(0, 0, 1, KV_EMPTY);
        chk("keyinf_deq", kvo, kv(32'hFFFFFFFF, 'h7));
        status("keyinf_deq", 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
